btn_mode_ctrl: RTL and testbench

Front-end controller for the four button-driven modes (watch, stopwatch, SR04, DHT11). It synchronizes and debounces the four board buttons and converts them to single-cycle press events. It merges those events with UART-decoded button events and owns the active-mode register, which is set by the `sw_sel` switches or by a UART mode command. Events go only to the active mode, and a hold-off window after each mode change blanks all events.

---
 rtl/btn_mode_pkg.sv | 17 +
 rtl/btn_debounce.sv | 46 ++++
 rtl/btn_mode_ctrl.sv | 105 ++++++++++
 tb/tb_btn_mode_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/btn_mode_pkg.sv
// Shared constants for the button/mode front-end: mode codes, FSM states
// and the button count.
package btn_mode_pkg;

  localparam int NUM_BTN = 4;

  localparam logic [1:0] MODE_WATCH     = 2'b00;
  localparam logic [1:0] MODE_STOPWATCH = 2'b01;
  localparam logic [1:0] MODE_SR04      = 2'b10;
  localparam logic [1:0] MODE_DHT11     = 2'b11;

  typedef enum logic {
    ST_ACTIVE = 1'b0,
    ST_SWITCH = 1'b1
  } state_t;

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchronizer, stability counter and a one-cycle pulse
// on each accepted rising level.
module btn_debounce
  import btn_mode_pkg::*;
#(
  parameter int DEB_CYCLES = 100_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  logic          sync_p0;
  logic          sync_p1;
  logic          stable;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      stable  <= 1'b0;
      cnt     <= '0;
      pulse   <= 1'b0;
    end else begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
      pulse   <= 1'b0;
      // Any agreeing sample restarts the count, so bounces never accumulate.
      if (sync_p1 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        stable <= sync_p1;
        cnt    <= '0;
        pulse  <= sync_p1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/btn_mode_ctrl.sv
// Button/mode front-end: debounced and UART events merged, routed to the
// active mode only, with a blanking hold-off after every mode change.
module btn_mode_ctrl
  import btn_mode_pkg::*;
#(
  parameter int DEB_CYCLES     = 100_000,
  parameter int HOLDOFF_CYCLES = 1_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] i_btn,
  input  logic [1:0]         sw_sel,
  input  logic               i_uart_btn_valid,
  input  logic [NUM_BTN-1:0] i_uart_btn,
  input  logic               i_uart_sel_valid,
  input  logic [1:0]         i_uart_sel,
  output logic [1:0]         o_mode,
  output logic               o_switching,
  output logic [NUM_BTN-1:0] o_btn_watch,
  output logic [NUM_BTN-1:0] o_btn_stopwatch,
  output logic [NUM_BTN-1:0] o_btn_sr04,
  output logic [NUM_BTN-1:0] o_btn_dht11
);

  localparam int HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLDOFF_CYCLES - 1);

  logic [NUM_BTN-1:0] hw_evt;
  logic [NUM_BTN-1:0] evt;
  logic [1:0]         sw_p0;
  logic [1:0]         sw_p1;
  logic [1:0]         last_sw;
  logic               sw_chg;
  logic               req_take;
  logic [1:0]         req_mode;
  state_t             state;
  logic [HW-1:0]      hold_cnt;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_deb
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (i_btn[i]),
      .pulse (hw_evt[i])
    );
  end

  assign evt      = hw_evt | (i_uart_btn_valid ? i_uart_btn : '0);
  assign sw_chg   = (sw_p1 != last_sw);
  // Switch wins over a simultaneous UART command; same-mode requests are no-ops.
  assign req_mode = sw_chg ? sw_p1 : i_uart_sel;
  assign req_take = (sw_chg || i_uart_sel_valid) && (req_mode != o_mode);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_p0           <= 2'b00;
      sw_p1           <= 2'b00;
      last_sw         <= 2'b00;
      state           <= ST_ACTIVE;
      hold_cnt        <= '0;
      o_mode          <= MODE_WATCH;
      o_switching     <= 1'b0;
      o_btn_watch     <= '0;
      o_btn_stopwatch <= '0;
      o_btn_sr04      <= '0;
      o_btn_dht11     <= '0;
    end else begin
      sw_p0           <= sw_sel;
      sw_p1           <= sw_p0;
      o_btn_watch     <= '0;
      o_btn_stopwatch <= '0;
      o_btn_sr04      <= '0;
      o_btn_dht11     <= '0;
      if (sw_chg) last_sw <= sw_p1;

      if (req_take) begin
        o_mode      <= req_mode;
        hold_cnt    <= '0;
        state       <= ST_SWITCH;
        o_switching <= 1'b1;
      end else begin
        case (state)
          ST_ACTIVE: begin
            case (o_mode)
              MODE_WATCH:     o_btn_watch     <= evt;
              MODE_STOPWATCH: o_btn_stopwatch <= evt;
              MODE_SR04:      o_btn_sr04      <= evt;
              default:        o_btn_dht11     <= evt;
            endcase
          end
          ST_SWITCH: begin
            if (hold_cnt == HOLD_MAX) begin
              state       <= ST_ACTIVE;
              o_switching <= 1'b0;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
          default: state <= ST_ACTIVE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_btn_mode_ctrl.sv
// Directed bench for btn_mode_ctrl with DEB_CYCLES=8 and HOLDOFF_CYCLES=16.
module tb_btn_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] i_btn;
  logic [1:0] sw_sel;
  logic       i_uart_btn_valid;
  logic [3:0] i_uart_btn;
  logic       i_uart_sel_valid;
  logic [1:0] i_uart_sel;
  logic [1:0] o_mode;
  logic       o_switching;
  logic [3:0] o_btn_watch, o_btn_stopwatch, o_btn_sr04, o_btn_dht11;

  int total = 0;
  int bad   = 0;

  btn_mode_ctrl #(.DEB_CYCLES(8), .HOLDOFF_CYCLES(16)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_btn            (i_btn),
    .sw_sel           (sw_sel),
    .i_uart_btn_valid (i_uart_btn_valid),
    .i_uart_btn       (i_uart_btn),
    .i_uart_sel_valid (i_uart_sel_valid),
    .i_uart_sel       (i_uart_sel),
    .o_mode           (o_mode),
    .o_switching      (o_switching),
    .o_btn_watch      (o_btn_watch),
    .o_btn_stopwatch  (o_btn_stopwatch),
    .o_btn_sr04       (o_btn_sr04),
    .o_btn_dht11      (o_btn_dht11)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 2 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_out(input string tag, input logic [1:0] mode, input logic sw,
                            input logic [3:0] w, input logic [3:0] s,
                            input logic [3:0] r, input logic [3:0] d);
    logic [18:0] obs;
    logic [18:0] exp;
    obs = {o_mode, o_switching, o_btn_watch, o_btn_stopwatch, o_btn_sr04, o_btn_dht11};
    exp = {mode, sw, w, s, r, d};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; i_btn = 4'b0; sw_sel = 2'b00;
    i_uart_btn_valid = 1'b0; i_uart_btn = 4'b0;
    i_uart_sel_valid = 1'b0; i_uart_sel = 2'b00;
    tick(); tick();
    expect_out("reset", 2'b00, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    rst_n = 1'b1;
    tick();
    expect_out("post_reset", 2'b00, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);

    // Clean press on button 0 in watch mode: pulse 11 cycles after the rise.
    i_btn = 4'b0001;
    for (int i = 1; i <= 10; i++) begin
      tick(); expect_out("press_wait", 2'b00, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    end
    tick(); expect_out("press_pulse", 2'b00, 1'b0, 4'h1, 4'h0, 4'h0, 4'h0);
    for (int i = 1; i <= 8; i++) begin
      tick(); expect_out("press_hold", 2'b00, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    end
    i_btn = 4'b0000;
    for (int i = 1; i <= 14; i++) begin
      tick(); expect_out("release_quiet", 2'b00, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    end

    // Bounce on button 2: 3-cycle toggles never qualify.
    for (int seg = 0; seg < 10; seg++) begin
      i_btn = (seg % 2 == 0) ? 4'b0100 : 4'b0000;
      for (int i = 0; i < 3; i++) begin
        tick(); expect_out("bounce_quiet", 2'b00, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
      end
    end
    i_btn = 4'b0100;
    for (int i = 1; i <= 10; i++) begin
      tick(); expect_out("bounce_wait", 2'b00, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    end
    tick(); expect_out("bounce_pulse", 2'b00, 1'b0, 4'h4, 4'h0, 4'h0, 4'h0);
    tick(); expect_out("bounce_after", 2'b00, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    i_btn = 4'b0000;
    for (int i = 1; i <= 14; i++) tick();

    // UART mode select to stopwatch: 16 cycles of blanking.
    i_uart_sel_valid = 1'b1; i_uart_sel = 2'b01;
    tick(); i_uart_sel_valid = 1'b0;
    expect_out("uart_sel_enter", 2'b01, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0);
    for (int i = 1; i <= 15; i++) begin
      tick(); expect_out("uart_sel_hold", 2'b01, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0);
    end
    tick(); expect_out("uart_sel_exit", 2'b01, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);

    // Merge: UART 0011 coincides with the hardware event of button 0.
    i_btn = 4'b0001;
    for (int i = 1; i <= 10; i++) begin
      tick(); expect_out("merge_wait", 2'b01, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    end
    i_uart_btn_valid = 1'b1; i_uart_btn = 4'b0011;
    tick(); i_uart_btn_valid = 1'b0; i_uart_btn = 4'b0000;
    expect_out("merge_pulse", 2'b01, 1'b0, 4'h0, 4'h3, 4'h0, 4'h0);
    tick(); expect_out("merge_after", 2'b01, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    i_btn = 4'b0000;
    for (int i = 1; i <= 14; i++) tick();

    // Switch path 00 -> 10: mode changes on the third edge.
    sw_sel = 2'b10;
    tick(); expect_out("sw_lat1", 2'b01, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    tick(); expect_out("sw_lat2", 2'b01, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    tick(); expect_out("sw_enter", 2'b10, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0);
    for (int i = 1; i <= 15; i++) begin
      if (i == 5) begin i_uart_btn_valid = 1'b1; i_uart_btn = 4'b1111; end
      tick();
      i_uart_btn_valid = 1'b0;
      expect_out("blank_drop", 2'b10, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0);
    end
    tick(); expect_out("blank_exit", 2'b10, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    i_uart_btn_valid = 1'b1; i_uart_btn = 4'b0100;
    tick(); i_uart_btn_valid = 1'b0; i_uart_btn = 4'b0000;
    expect_out("first_after_blank", 2'b10, 1'b0, 4'h0, 4'h0, 4'h4, 4'h0);

    // Request equal to the current mode is ignored.
    i_uart_sel_valid = 1'b1; i_uart_sel = 2'b10;
    tick(); i_uart_sel_valid = 1'b0;
    expect_out("same_mode_ignored", 2'b10, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);

    // Simultaneous switch (01) and UART (11): switch wins; later UART restarts hold-off.
    sw_sel = 2'b01;
    tick(); expect_out("simul_lat1", 2'b10, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    tick(); expect_out("simul_lat2", 2'b10, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    i_uart_sel_valid = 1'b1; i_uart_sel = 2'b11;
    tick(); i_uart_sel_valid = 1'b0;
    expect_out("simul_sw_wins", 2'b01, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0);
    for (int i = 1; i <= 7; i++) begin
      tick(); expect_out("simul_hold", 2'b01, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0);
    end
    i_uart_sel_valid = 1'b1; i_uart_sel = 2'b11;
    tick(); i_uart_sel_valid = 1'b0;
    expect_out("restart_enter", 2'b11, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0);
    for (int i = 1; i <= 15; i++) begin
      tick(); expect_out("restart_hold", 2'b11, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0);
    end
    tick(); expect_out("restart_exit", 2'b11, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);

    // Reset mid-hold-off with button 3 held.
    sw_sel = 2'b10; i_btn = 4'b1000;
    for (int i = 1; i <= 5; i++) tick();
    expect_out("pre_reset_switch", 2'b10, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0);
    rst_n = 1'b0;
    #1;
    expect_out("async_reset", 2'b00, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    sw_sel = 2'b00;
    tick(); tick();
    expect_out("reset_held", 2'b00, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    rst_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick(); expect_out("rst_press_wait", 2'b00, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    end
    tick(); expect_out("rst_press_pulse", 2'b00, 1'b0, 4'h8, 4'h0, 4'h0, 4'h0);
    tick(); expect_out("rst_press_after", 2'b00, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
